// File: rtl/phys_reg_rename_ctrl_if.sv
// Decode/commit/flush bundle for the physical register rename controller.
// Optional counters appear when PHYS_RENAME_STATS_EN is defined.
interface phys_reg_rename_ctrl_if #(
   parameter int ARCH_W = 5,
   parameter int TAG_W  = 6
);
   // Allocation handshake: a mapping is taken on a rising edge where
   // alloc_valid && alloc_ready; alloc_tag/alloc_old_tag are valid in that same cycle.
   logic              alloc_valid;
   logic [ARCH_W-1:0] alloc_arch;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;
   logic [TAG_W-1:0]  alloc_old_tag;
   logic [ARCH_W-1:0] rs_arch;
   logic [TAG_W-1:0]  rs_tag;
   logic [ARCH_W-1:0] rt_arch;
   logic [TAG_W-1:0]  rt_tag;
   logic              commit_valid;
   logic [ARCH_W-1:0] commit_arch;
   logic [TAG_W-1:0]  commit_tag;
   logic              flush;
   logic [TAG_W:0]    free_count;
   logic              dbg_state;
`ifdef PHYS_RENAME_STATS_EN
   logic [31:0]       alloc_stall_cycles;
   logic [15:0]       flush_count;
`endif

   modport master (
      output alloc_valid, alloc_arch, rs_arch, rt_arch,
             commit_valid, commit_arch, commit_tag, flush,
      input  alloc_ready, alloc_tag, alloc_old_tag, rs_tag, rt_tag,
             free_count, dbg_state
`ifdef PHYS_RENAME_STATS_EN
      , input alloc_stall_cycles, flush_count
`endif
   );

   modport slave (
      input  alloc_valid, alloc_arch, rs_arch, rt_arch,
             commit_valid, commit_arch, commit_tag, flush,
      output alloc_ready, alloc_tag, alloc_old_tag, rs_tag, rt_tag,
             free_count, dbg_state
`ifdef PHYS_RENAME_STATS_EN
      , output alloc_stall_cycles, flush_count
`endif
   );
endinterface

// File: rtl/phys_reg_rename_ctrl.sv
// Rename controller: speculative/committed arch->phys maps plus free vector.
// Define PHYS_RENAME_STATS_EN to add stall-cycle and flush counters.
module phys_reg_rename_ctrl #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64,
   parameter int TAG_W     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   phys_reg_rename_ctrl_if.slave rn
);
   localparam int ARCH_W = $clog2(ARCH_REGS);
   localparam int CNT_W  = TAG_W + 1;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [TAG_W-1:0]  spec_map_q [ARCH_REGS];
   logic [TAG_W-1:0]  spec_map_d [ARCH_REGS];
   logic [TAG_W-1:0]  comm_map_q [ARCH_REGS];
   logic [TAG_W-1:0]  comm_map_d [ARCH_REGS];
   logic [PHYS_REGS-1:0] free_q, free_d;
   logic [CNT_W-1:0]  free_cnt_q, free_cnt_d;

   logic [TAG_W-1:0]  free_tag;
   logic              arch_zero;
   logic              alloc_ready;
   logic              alloc_take;
   logic              commit_en;
   logic [TAG_W-1:0]  old_comm_tag;

   // Lowest-indexed free tag; the loop runs high to low so the last hit wins.
   always_comb begin
      free_tag = '0;
      for (int t = PHYS_REGS - 1; t >= 0; t--) begin
         if (free_q[t]) free_tag = TAG_W'(t);
      end
   end

   always_comb begin
      state_d     = ST_RUN;
      alloc_ready = 1'b0;
      case (state_q)
         ST_RUN: begin
            alloc_ready = !rn.flush && (free_cnt_q != '0 || arch_zero);
            state_d     = rn.flush ? ST_RECOVER : ST_RUN;
         end
         ST_RECOVER: begin
            alloc_ready = 1'b0;
            state_d     = rn.flush ? ST_RECOVER : ST_RUN;
         end
         default: begin
            alloc_ready = 1'b0;
            state_d     = ST_RUN;
         end
      endcase
   end

   assign arch_zero        = (rn.alloc_arch == '0);
   assign alloc_take       = rn.alloc_valid && alloc_ready && !arch_zero;
   assign commit_en        = rn.commit_valid && (rn.commit_arch != '0);
   assign old_comm_tag     = comm_map_q[rn.commit_arch];

   assign rn.alloc_ready   = alloc_ready;
   assign rn.alloc_tag     = arch_zero ? '0 : free_tag;
   assign rn.alloc_old_tag = arch_zero ? '0 : spec_map_q[rn.alloc_arch];
   assign rn.rs_tag        = spec_map_q[rn.rs_arch];
   assign rn.rt_tag        = spec_map_q[rn.rt_arch];
   assign rn.free_count    = free_cnt_q;
   assign rn.dbg_state     = state_q;

   always_comb begin
      spec_map_d = spec_map_q;
      comm_map_d = comm_map_q;
      free_d     = free_q;
      free_cnt_d = free_cnt_q;

      if (commit_en) comm_map_d[rn.commit_arch] = rn.commit_tag;

      if (rn.flush) begin
         // Rebuild from the committed map after this cycle's commit lands.
         spec_map_d = comm_map_d;
         free_d     = '1;
         for (int i = 0; i < ARCH_REGS; i++) begin
            free_d[comm_map_d[i]] = 1'b0;
         end
         free_cnt_d = CNT_W'(PHYS_REGS - ARCH_REGS);
      end else begin
         if (alloc_take) begin
            free_d[free_tag]          = 1'b0;
            spec_map_d[rn.alloc_arch] = free_tag;
         end
         if (commit_en) free_d[old_comm_tag] = 1'b1;
         case ({commit_en, alloc_take})
            2'b10:   free_cnt_d = free_cnt_q + CNT_W'(1);
            2'b01:   free_cnt_d = free_cnt_q - CNT_W'(1);
            default: free_cnt_d = free_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         free_q     <= {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
         free_cnt_q <= CNT_W'(PHYS_REGS - ARCH_REGS);
         for (int i = 0; i < ARCH_REGS; i++) begin
            spec_map_q[i] <= TAG_W'(i);
            comm_map_q[i] <= TAG_W'(i);
         end
      end else begin
         state_q    <= state_d;
         free_q     <= free_d;
         free_cnt_q <= free_cnt_d;
         spec_map_q <= spec_map_d;
         comm_map_q <= comm_map_d;
      end
   end

`ifdef PHYS_RENAME_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_d     = stall_q;
      flush_cnt_d = flush_cnt_q;
      if (rn.alloc_valid && !alloc_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
      if (rn.flush) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q     <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_q     <= stall_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign rn.alloc_stall_cycles = stall_q;
   assign rn.flush_count        = flush_cnt_q;
`endif

   logic unused_width;
   assign unused_width = ^ARCH_W;
endmodule

// File: tb/tb_phys_reg_rename_ctrl.sv
// Self-checking bench for phys_reg_rename_ctrl: per-scenario tasks with an
// expected-tag queue filled when allocations are driven.
module tb_phys_reg_rename_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   phys_reg_rename_ctrl_if rn ();
   phys_reg_rename_ctrl dut (.clk(clk), .rst(rst), .rn(rn.slave));

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_tag;

   task automatic idle();
      rn.alloc_valid  = 1'b0;
      rn.alloc_arch   = 5'd0;
      rn.rs_arch      = 5'd0;
      rn.rt_arch      = 5'd0;
      rn.commit_valid = 1'b0;
      rn.commit_arch  = 5'd0;
      rn.commit_tag   = 6'd0;
      rn.flush        = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive_alloc(input logic [4:0] arch, input logic [5:0] tag);
      rn.alloc_valid = 1'b1;
      rn.alloc_arch  = arch;
      exp_q.push_back(tag);
   endtask

   task automatic test_reset();
      do_reset();
      rn.alloc_arch = 5'd9;
      @(negedge clk);
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL reset_free_count got=%0d exp=32", rn.free_count); end
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%b exp=1", rn.alloc_ready); end
      total++; if (rn.dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", rn.dbg_state); end
      total++; if (rn.alloc_tag !== 6'd32) begin bad++; $display("FAIL reset_alloc_tag got=%0d exp=32", rn.alloc_tag); end
      for (int i = 0; i < 32; i++) begin
         rn.rs_arch = 5'(i);
         rn.rt_arch = 5'(31 - i);
         #0.1;
         total++; if (rn.rs_tag !== 6'(i)) begin bad++; $display("FAIL reset_rs_map arch=%0d got=%0d exp=%0d", i, rn.rs_tag, i); end
         total++; if (rn.rt_tag !== 6'(31 - i)) begin bad++; $display("FAIL reset_rt_map arch=%0d got=%0d exp=%0d", 31 - i, rn.rt_tag, 31 - i); end
      end
      idle();
      cyc();
   endtask

   task automatic test_basic_alloc();
      do_reset();
      drive_alloc(5'd5, 6'd32);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL basic_alloc_tag got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      total++; if (rn.alloc_old_tag !== 6'd5) begin bad++; $display("FAIL basic_old_tag got=%0d exp=5", rn.alloc_old_tag); end
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", rn.alloc_ready); end
      rn.rs_arch = 5'd5;
      #0.1;
      total++; if (rn.rs_tag !== 6'd5) begin bad++; $display("FAIL basic_rs_before_write got=%0d exp=5", rn.rs_tag); end
      cyc();
      idle();
      rn.rs_arch = 5'd5;
      @(negedge clk);
      total++; if (rn.rs_tag !== 6'd32) begin bad++; $display("FAIL basic_rs_after got=%0d exp=32", rn.rs_tag); end
      total++; if (rn.free_count !== 7'd31) begin bad++; $display("FAIL basic_free_count got=%0d exp=31", rn.free_count); end
      cyc();
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         drive_alloc(5'd1, 6'(32 + i));
         @(negedge clk);
         exp_tag = exp_q.pop_front();
         total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL exhaust_tag i=%0d got=%0d exp=%0d", i, rn.alloc_tag, exp_tag); end
         total++; if (rn.alloc_old_tag !== ((i == 0) ? 6'd1 : 6'(31 + i))) begin bad++; $display("FAIL exhaust_old i=%0d got=%0d", i, rn.alloc_old_tag); end
         cyc();
      end
      rn.alloc_valid = 1'b0;
      rn.alloc_arch  = 5'd1;
      @(negedge clk);
      total++; if (rn.alloc_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%b exp=0", rn.alloc_ready); end
      total++; if (rn.free_count !== 7'd0) begin bad++; $display("FAIL empty_free_count got=%0d exp=0", rn.free_count); end
      cyc();
      // arch 0 is accepted even with nothing free
      drive_alloc(5'd0, 6'd0);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL arch0_ready got=%b exp=1", rn.alloc_ready); end
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL arch0_tag got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      total++; if (rn.alloc_old_tag !== 6'd0) begin bad++; $display("FAIL arch0_old got=%0d exp=0", rn.alloc_old_tag); end
      cyc();
      idle();
      @(negedge clk);
      total++; if (rn.free_count !== 7'd0) begin bad++; $display("FAIL arch0_free_count got=%0d exp=0", rn.free_count); end
      total++; if (rn.rs_tag !== 6'd0) begin bad++; $display("FAIL arch0_map got=%0d exp=0", rn.rs_tag); end
      cyc();
      rn.commit_valid = 1'b1;
      rn.commit_arch  = 5'd1;
      rn.commit_tag   = 6'd32;
      rn.alloc_arch   = 5'd1;
      @(negedge clk);
      total++; if (rn.alloc_ready !== 1'b0) begin bad++; $display("FAIL commit_not_yet_ready got=%b exp=0", rn.alloc_ready); end
      cyc();
      rn.commit_valid = 1'b0;
      @(negedge clk);
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL refill_ready got=%b exp=1", rn.alloc_ready); end
      total++; if (rn.alloc_tag !== 6'd1) begin bad++; $display("FAIL refill_tag got=%0d exp=1", rn.alloc_tag); end
      total++; if (rn.free_count !== 7'd1) begin bad++; $display("FAIL refill_free_count got=%0d exp=1", rn.free_count); end
      idle();
      cyc();
   endtask

   task automatic test_flush();
      do_reset();
      drive_alloc(5'd3, 6'd32);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL flush_alloc3 got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      cyc();
      drive_alloc(5'd4, 6'd33);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL flush_alloc4 got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      cyc();
      idle();
      rn.commit_valid = 1'b1;
      rn.commit_arch  = 5'd3;
      rn.commit_tag   = 6'd32;
      cyc();
      idle();
      rn.flush      = 1'b1;
      rn.alloc_arch = 5'd9;
      @(negedge clk);
      total++; if (rn.alloc_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle_ready got=%b exp=0", rn.alloc_ready); end
      cyc();
      rn.flush       = 1'b0;
      rn.alloc_valid = 1'b1;
      rn.alloc_arch  = 5'd9;
      @(negedge clk);
      total++; if (rn.dbg_state !== 1'b1) begin bad++; $display("FAIL recover_state got=%b exp=1", rn.dbg_state); end
      total++; if (rn.alloc_ready !== 1'b0) begin bad++; $display("FAIL recover_ready got=%b exp=0", rn.alloc_ready); end
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL recover_free_count got=%0d exp=32", rn.free_count); end
      cyc();
      rn.alloc_valid = 1'b0;
      rn.rs_arch     = 5'd3;
      rn.rt_arch     = 5'd4;
      @(negedge clk);
      total++; if (rn.dbg_state !== 1'b0) begin bad++; $display("FAIL post_flush_state got=%b exp=0", rn.dbg_state); end
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL post_flush_ready got=%b exp=1", rn.alloc_ready); end
      total++; if (rn.rs_tag !== 6'd32) begin bad++; $display("FAIL post_flush_rs got=%0d exp=32", rn.rs_tag); end
      total++; if (rn.rt_tag !== 6'd4) begin bad++; $display("FAIL post_flush_rt got=%0d exp=4", rn.rt_tag); end
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL post_flush_free_count got=%0d exp=32", rn.free_count); end
      total++; if (rn.alloc_tag !== 6'd3) begin bad++; $display("FAIL post_flush_alloc_tag got=%0d exp=3", rn.alloc_tag); end
      idle();
      cyc();
   endtask

   task automatic test_flush_with_commit();
      do_reset();
      drive_alloc(5'd6, 6'd32);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL fc_alloc6 got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      cyc();
      idle();
      rn.commit_valid = 1'b1;
      rn.commit_arch  = 5'd6;
      rn.commit_tag   = 6'd32;
      rn.flush        = 1'b1;
      cyc();
      rn.commit_arch = 5'd7;
      rn.commit_tag  = 6'd40;
      rn.rs_arch     = 5'd6;
      @(negedge clk);
      total++; if (rn.rs_tag !== 6'd32) begin bad++; $display("FAIL fc_rs6 got=%0d exp=32", rn.rs_tag); end
      total++; if (rn.dbg_state !== 1'b1) begin bad++; $display("FAIL fc_state1 got=%b exp=1", rn.dbg_state); end
      cyc();
      idle();
      rn.rs_arch = 5'd7;
      @(negedge clk);
      total++; if (rn.dbg_state !== 1'b1) begin bad++; $display("FAIL fc_reflush_state got=%b exp=1", rn.dbg_state); end
      total++; if (rn.rs_tag !== 6'd40) begin bad++; $display("FAIL fc_rs7 got=%0d exp=40", rn.rs_tag); end
      cyc();
      rn.alloc_arch = 5'd9;
      @(negedge clk);
      total++; if (rn.dbg_state !== 1'b0) begin bad++; $display("FAIL fc_run_state got=%b exp=0", rn.dbg_state); end
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL fc_free_count got=%0d exp=32", rn.free_count); end
      total++; if (rn.alloc_tag !== 6'd6) begin bad++; $display("FAIL fc_alloc_tag got=%0d exp=6", rn.alloc_tag); end
      idle();
      cyc();
   endtask

   task automatic test_back_to_back_commit();
      do_reset();
      drive_alloc(5'd7, 6'd32);
      rn.commit_valid = 1'b1;
      rn.commit_arch  = 5'd2;
      rn.commit_tag   = 6'd2;
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL same_cycle_tag got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      cyc();
      idle();
      drive_alloc(5'd8, 6'd2);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL same_cycle_free_count got=%0d exp=32", rn.free_count); end
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL next_cycle_tag got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      idle();
      cyc();
   endtask

   task automatic test_reset_mid_recover();
      do_reset();
      drive_alloc(5'd5, 6'd32);
      @(negedge clk);
      exp_tag = exp_q.pop_front();
      total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL mr_alloc got=%0d exp=%0d", rn.alloc_tag, exp_tag); end
      cyc();
      idle();
      rn.flush = 1'b1;
      cyc();
      idle();
      rn.alloc_arch = 5'd9;
      rn.rs_arch    = 5'd5;
      @(negedge clk);
      total++; if (rn.dbg_state !== 1'b1) begin bad++; $display("FAIL mr_in_recover got=%b exp=1", rn.dbg_state); end
      #1;
      rst = 1'b1;
      #1;
      total++; if (rn.dbg_state !== 1'b0) begin bad++; $display("FAIL mr_state got=%b exp=0", rn.dbg_state); end
      total++; if (rn.alloc_ready !== 1'b1) begin bad++; $display("FAIL mr_ready got=%b exp=1", rn.alloc_ready); end
      total++; if (rn.free_count !== 7'd32) begin bad++; $display("FAIL mr_free_count got=%0d exp=32", rn.free_count); end
      total++; if (rn.rs_tag !== 6'd5) begin bad++; $display("FAIL mr_map got=%0d exp=5", rn.rs_tag); end
      total++; if (rn.alloc_tag !== 6'd32) begin bad++; $display("FAIL mr_alloc_tag got=%0d exp=32", rn.alloc_tag); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_random_allocs();
      logic [5:0] model_map [32];
      logic [5:0] next_tag;
      logic [4:0] arch;
      do_reset();
      for (int i = 0; i < 32; i++) model_map[i] = 6'(i);
      next_tag = 6'd32;
      for (int k = 0; k < 12; k++) begin
         arch = 5'($urandom_range(1, 31));
         drive_alloc(arch, next_tag);
         @(negedge clk);
         exp_tag = exp_q.pop_front();
         total++; if (rn.alloc_tag !== exp_tag) begin bad++; $display("FAIL rand_tag k=%0d got=%0d exp=%0d", k, rn.alloc_tag, exp_tag); end
         total++; if (rn.alloc_old_tag !== model_map[arch]) begin bad++; $display("FAIL rand_old k=%0d got=%0d exp=%0d", k, rn.alloc_old_tag, model_map[arch]); end
         cyc();
         model_map[arch] = next_tag;
         next_tag = next_tag + 6'd1;
      end
      idle();
      for (int i = 1; i < 32; i++) begin
         rn.rs_arch = 5'(i);
         #0.1;
         total++; if (rn.rs_tag !== model_map[i]) begin bad++; $display("FAIL rand_map arch=%0d got=%0d exp=%0d", i, rn.rs_tag, model_map[i]); end
      end
      @(negedge clk);
      total++; if (rn.free_count !== 7'd20) begin bad++; $display("FAIL rand_free_count got=%0d exp=20", rn.free_count); end
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_alloc();
      test_exhaust();
      test_flush();
      test_flush_with_commit();
      test_back_to_back_commit();
      test_reset_mid_recover();
      test_random_allocs();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
